act_lut_loader: RTL and testbench

- Writer side of the sigmoid activation lookup table: accepts table words over a valid/ready stream and writes them sequentially into an on-chip LUT RAM.
- Once the table is fully loaded, the block serves activation lookups using the table's signed-input addressing (MSB-flip offset).
- Sits between the weight/config loader and the neuron output stage, and replaces the static file-initialised table with a runtime-programmable one.

---
 rtl/act_lut_loader_pkg.sv | 18 +
 rtl/act_lut_ram.sv | 23 ++
 rtl/act_lut_loader.sv | 95 +++++++++
 tb/tb_act_lut_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/act_lut_loader_pkg.sv
// Shared definitions for the runtime-programmable activation LUT:
// FSM encoding, default geometry and the signed-input address helper.
package act_lut_loader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam int unsigned IN_W_DEF  = 10;
  localparam int unsigned LUT_DEPTH = 2 ** IN_W_DEF;

  // Signed input -> table index: flipping the MSB offsets by half the depth,
  // so the most negative input lands on entry 0.
  function automatic logic [31:0] msb_flip(input logic [31:0] x, input int unsigned w);
    return x ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/act_lut_ram.sv
// Simple dual-port table RAM: one write port, one registered read port, no reset.
module act_lut_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/act_lut_loader.sv
// Streams sigmoid table words into the LUT RAM, then serves 2-cycle lookups
// addressed by the signed pre-activation input.
module act_lut_loader
  import act_lut_loader_pkg::*;
#(
  parameter int inWidth   = 10,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [dataWidth-1:0] cfg_data,
  output logic                 busy,
  output logic                 load_done,
  input  logic                 x_valid,
  input  logic [inWidth-1:0]   x,
  output logic                 out_valid,
  output logic [dataWidth-1:0] out
);

  logic [1:0]           state_q, state_d;
  logic [inWidth-1:0]   wr_addr_q, wr_addr_d;
  logic                 we;
  logic [inWidth-1:0]   raddr;
  logic [dataWidth-1:0] rdata;
  logic [1:0]           vld_pipe_q;
  logic [dataWidth-1:0] out_q;

  assign cfg_ready = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD);
  assign load_done = (state_q == ST_READY);

  // A restart always wins over a word offered in the same cycle.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    we        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d   = ST_LOAD;
          wr_addr_d = '0;
        end
      end
      ST_LOAD: begin
        if (cfg_start) begin
          wr_addr_d = '0;
        end else if (cfg_valid) begin
          we        = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == {inWidth{1'b1}}) state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (cfg_start) begin
          state_d   = ST_LOAD;
          wr_addr_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign raddr = inWidth'(msb_flip(32'(x), inWidth));

  // RAM read register is lookup stage 1; out_q is stage 2.
  act_lut_ram #(.AW(inWidth), .DW(dataWidth)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_addr_q),
    .wdata (cfg_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      vld_pipe_q <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      vld_pipe_q <= {vld_pipe_q[0], x_valid && (state_q == ST_READY)};
      if (vld_pipe_q[0]) out_q <= rdata;
    end
  end

  assign out_valid = vld_pipe_q[1];
  assign out       = out_q;

endmodule

// File: tb/tb_act_lut_loader.sv
// Scoreboard bench for act_lut_loader: stimulus pushes expected lookups,
// a negedge monitor pops and checks value and arrival cycle.
module tb_act_lut_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start, cfg_valid, cfg_ready;
  logic [15:0] cfg_data;
  logic        busy, load_done;
  logic        x_valid;
  logic [9:0]  x;
  logic        out_valid;
  logic [15:0] out;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   vecs   = 0;
  int   errs   = 0;
  int   ov_cnt = 0;

  act_lut_loader #(.inWidth(10), .dataWidth(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .busy      (busy),
    .load_done (load_done),
    .x_valid   (x_valid),
    .x         (x),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int pat, input int k);
    logic [15:0] kk;
    kk = 16'(k);
    case (pat)
      0:       return kk;
      1:       return ~kk;
      2:       return kk ^ 16'hA5A5;
      default: return kk + 16'h1000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      ov_cnt++;
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("lookup_data", 32'(out), 32'(e.d));
        check("lookup_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [9:0] xv, input logic [15:0] d);
    exp_t e;
    x_valid = 1'b1;
    x       = xv;
    e.d     = d;
    e.due   = cyc + 2;
    q.push_back(e);
    tick();
    x_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 20) begin
      tick();
      g++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  // Optionally issue a lookup alongside the start pulse (last READY cycle).
  task automatic start(input bit with_lookup, input logic [9:0] xv, input logic [15:0] d);
    exp_t e;
    cfg_start = 1'b1;
    cfg_valid = 1'b0;
    if (with_lookup) begin
      x_valid = 1'b1;
      x       = xv;
      e.d     = d;
      e.due   = cyc + 2;
      q.push_back(e);
    end
    tick();
    cfg_start = 1'b0;
    x_valid   = 1'b0;
  endtask

  task automatic load(input int n, input int pat, input bit stall);
    int acc = 0, guard = 0, busy_low = 0;
    while (acc < n && guard < 5000) begin
      cfg_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_data  = exp_word(pat, acc);
      if (!busy) busy_low++;
      if (cfg_valid && cfg_ready) acc++;
      tick();
      guard++;
    end
    cfg_valid = 1'b0;
    check("accepts", 32'(acc), 32'(n));
    if (stall) check("busy_throughout", 32'(busy_low), 32'd0);
    if (n == 1024) begin
      check("load_done_after_last", 32'(load_done), 32'd1);
      check("cfg_ready_dropped", 32'(cfg_ready), 32'd0);
      check("busy_dropped", 32'(busy), 32'd0);
    end else begin
      check("busy_mid_load", 32'(busy), 32'd1);
    end
  endtask

  task automatic verify(input int pat);
    for (int k = 0; k < 1024; k++) lookup(10'(k) ^ 10'h200, exp_word(pat, k));
    drain();
  endtask

  initial begin
    int ov0;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    x_valid = 1'b0; x = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    rst_n = 1'b1;
    tick();

    // Lookup in IDLE is dropped
    ov0 = ov_cnt;
    x_valid = 1'b1; x = 10'd0;
    tick();
    x_valid = 1'b0;
    repeat (4) tick();
    check("idle_gate", 32'(ov_cnt - ov0), 32'd0);

    // Reset in the middle of a load
    start(1'b0, '0, '0);
    load(500, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("midrst_load_done", 32'(load_done), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full load data[k]=k and spot lookups
    start(1'b0, '0, '0);
    load(1024, 0, 1'b0);
    lookup(10'd0,   16'd512);  tick();
    lookup(10'h200, 16'd0);    tick();
    lookup(10'd511, 16'd1023); tick();
    lookup(10'h3FF, 16'd511);  tick();
    drain();

    // Back-to-back burst of 8
    ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) lookup(10'(100 + i), 16'(612 + i));
    drain();
    check("burst_count", 32'(ov_cnt - ov0), 32'd8);

    // Lookup on the start cycle still completes; then stalled load
    start(1'b1, 10'h3FF, 16'd511);
    load(1024, 2, 1'b1);
    verify(2);

    // Lookup during LOAD dropped; restart after 300 words
    start(1'b0, '0, '0);
    ov0 = ov_cnt;
    x_valid = 1'b1; x = 10'd5;
    tick();
    x_valid = 1'b0;
    repeat (3) tick();
    check("load_gate", 32'(ov_cnt - ov0), 32'd0);
    load(300, 0, 1'b0);
    start(1'b0, '0, '0);
    load(1024, 1, 1'b0);
    verify(1);

    // cfg_start with the final word: restart wins
    start(1'b0, '0, '0);
    load(1023, 2, 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = exp_word(2, 1023);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check("simul_busy", 32'(busy), 32'd1);
    check("simul_load_done", 32'(load_done), 32'd0);
    check("simul_cfg_ready", 32'(cfg_ready), 32'd1);
    load(1024, 3, 1'b0);
    verify(3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
